// File: rtl/data_out_controller.sv
// ---------------------------------------------------------------------------
// data_out_controller
//
// Transmit half of an I2C slave for master-read transfers. Once the slave top
// has acknowledged a read address it raises 'enable'; from then on every
// falling SCL edge moves the slave forward one bit. Bytes come from a
// valid/ready source, go out MSB first, and after each byte the master's
// ACK/NACK is sampled on the ninth SCL rise. The SDA pad is open-drain, so
// this block only asks for a pull-low through SDA_down.
//
// Build option (macro DATA_OUT_CLOCK_STRETCH_EN):
//   defined   - an empty source in LOAD stretches the clock (SCL_down=1)
//               until a byte arrives.
//   undefined - an empty source sends 0xFF and pulses 'underrun';
//               SCL_down is a constant 0.
//
// Ports:
//   FPGA_clk   in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   SCL, SDA   in   bus clock/data, already synchronised to FPGA_clk
//   enable     in   read transfer armed (level)
//   tx_data    in   next byte to send
//   tx_valid   in   tx_data is valid
//   tx_ready   out  byte taken this cycle when tx_valid & tx_ready
//   SDA_down   out  1 = pull SDA low
//   SCL_down   out  1 = hold SCL low (clock stretch)
//   done       out  one-cycle pulse at transfer end (NACK or STOP)
//   nack       out  master NACKed the last byte; held until next start
//   underrun   out  one-cycle pulse when 0xFF is sent for lack of data
//   byte_count out  bytes fully shifted this transfer, saturating
//   busy       out  controller not idle
// ---------------------------------------------------------------------------
module data_out_controller #(
    parameter int NUM_BYTES = 6
) (
    input  logic                       FPGA_clk,
    input  logic                       rst_n,
    input  logic                       SCL,
    input  logic                       SDA,
    input  logic                       enable,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       SDA_down,
    output logic                       SCL_down,
    output logic                       done,
    output logic                       nack,
    output logic                       underrun,
    output logic [$clog2(NUM_BYTES):0] byte_count,
    output logic                       busy
);

    localparam int BC_W = $clog2(NUM_BYTES) + 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRIVE,
        ACK_SLOT
    } state_t;

    state_t     state;
    logic       SCL_prev;
    logic       SDA_prev;
    logic [7:0] shift_reg;
    logic [2:0] bit_count;

    logic fall;
    logic rise;
    logic stop_cond;
    logic start_cond;

    assign fall       = ~SCL & SCL_prev;
    assign rise       =  SCL & ~SCL_prev;
    assign stop_cond  =  SCL & SCL_prev & SDA & ~SDA_prev;
    assign start_cond =  SCL & SCL_prev & ~SDA & SDA_prev;

    assign busy = (state != IDLE);

    // Only offer to take a byte when this cycle really ends in LOAD handling;
    // an abort in the same cycle would otherwise swallow a byte from the source.
    assign tx_ready = (state == LOAD) && enable && !(stop_cond || start_cond);

`ifndef DATA_OUT_CLOCK_STRETCH_EN
    assign SCL_down = 1'b0;
`endif

    always_ff @(posedge FPGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            SCL_prev   <= 1'b1;
            SDA_prev   <= 1'b1;
            shift_reg  <= 8'hFF;
            bit_count  <= 3'd0;
            byte_count <= '0;
            SDA_down   <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            underrun   <= 1'b0;
`ifdef DATA_OUT_CLOCK_STRETCH_EN
            SCL_down   <= 1'b0;
`endif
        end else begin
            SCL_prev <= SCL;
            SDA_prev <= SDA;
            done     <= 1'b0;
            underrun <= 1'b0;

            // Aborts take priority: losing enable is silent, a bus STOP or
            // repeated START ends the transfer (STOP reports done).
            if (state != IDLE && !enable) begin
                state    <= IDLE;
                SDA_down <= 1'b0;
`ifdef DATA_OUT_CLOCK_STRETCH_EN
                SCL_down <= 1'b0;
`endif
            end else if (state != IDLE && (stop_cond || start_cond)) begin
                state    <= IDLE;
                SDA_down <= 1'b0;
                done     <= stop_cond;
`ifdef DATA_OUT_CLOCK_STRETCH_EN
                SCL_down <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        SDA_down <= 1'b0;
`ifdef DATA_OUT_CLOCK_STRETCH_EN
                        SCL_down <= 1'b0;
`endif
                        // The fall that ends the address ACK opens the first data bit.
                        if (enable && fall) begin
                            state      <= LOAD;
                            nack       <= 1'b0;
                            byte_count <= '0;
                            bit_count  <= 3'd0;
                        end
                    end

                    LOAD: begin
                        bit_count <= 3'd0;
                        if (tx_valid) begin
                            shift_reg <= tx_data;
                            SDA_down  <= ~tx_data[7];
                            state     <= DRIVE;
`ifdef DATA_OUT_CLOCK_STRETCH_EN
                            SCL_down  <= 1'b0;
`endif
                        end else begin
`ifdef DATA_OUT_CLOCK_STRETCH_EN
                            SCL_down  <= 1'b1;
`else
                            // Released SDA reads as ones, so 0xFF is what the
                            // master sees anyway.
                            shift_reg <= 8'hFF;
                            SDA_down  <= 1'b0;
                            underrun  <= 1'b1;
                            state     <= DRIVE;
`endif
                        end
                    end

                    DRIVE: begin
                        // shift_reg[7] is already on the wire, so the next
                        // bit to present is shift_reg[6].
                        if (fall) begin
                            if (bit_count != 3'd7) begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                SDA_down  <= ~shift_reg[6];
                                bit_count <= bit_count + 3'd1;
                            end else begin
                                SDA_down <= 1'b0;
                                state    <= ACK_SLOT;
                                if (byte_count != BC_MAX) begin
                                    byte_count <= byte_count + BC_W'(1);
                                end
                            end
                        end
                    end

                    ACK_SLOT: begin
                        SDA_down <= 1'b0;
                        if (rise) begin
                            nack <= SDA;
                        end else if (fall) begin
                            if (nack) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_out_controller.sv
// ---------------------------------------------------------------------------
// tb_data_out_controller
//
// Plays an I2C master reading from data_out_controller. The master drives
// SCL/SDA directly, a queue acts as the byte source, and each test compares
// the bytes seen on the wire, ACK-slot release, nack, byte_count and pulse
// counts against values worked out from the byte lists it pushed.
// Honours DATA_OUT_CLOCK_STRETCH_EN to pick the underrun or stretch scenario.
// ---------------------------------------------------------------------------
module tb_data_out_controller;

    localparam int NUM_BYTES = 6;
    localparam int BC_W      = $clog2(NUM_BYTES) + 1;

    logic            FPGA_clk = 1'b0;
    logic            rst_n;
    logic            SCL;
    logic            SDA;
    logic            enable;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            SDA_down;
    logic            SCL_down;
    logic            done;
    logic            nack;
    logic            underrun;
    logic [BC_W-1:0] byte_count;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    int done_cnt;
    int underrun_cnt;
    int stretch_cnt;
    int hs_cnt;
    int viol_cnt;
    int low_t;
    int high_t;

    logic [7:0] src_q[$];

    data_out_controller #(.NUM_BYTES(NUM_BYTES)) dut (
        .FPGA_clk  (FPGA_clk),
        .rst_n     (rst_n),
        .SCL       (SCL),
        .SDA       (SDA),
        .enable    (enable),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .SDA_down  (SDA_down),
        .SCL_down  (SCL_down),
        .done      (done),
        .nack      (nack),
        .underrun  (underrun),
        .byte_count(byte_count),
        .busy      (busy)
    );

    always #5 FPGA_clk = ~FPGA_clk;

    // Present the head of the source queue; junk data when empty.
    task automatic set_source();
        if (src_q.size() != 0) begin
            tx_valid = 1'b1;
            tx_data  = src_q[0];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic clear_monitors();
        done_cnt     = 0;
        underrun_cnt = 0;
        stretch_cnt  = 0;
        hs_cnt       = 0;
        viol_cnt     = 0;
    endtask

    // Advance n clocks from one falling edge to the next, recording
    // handshakes, pulses and any SDA_down change made while SCL was high.
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            logic hs;
            logic scl_now;
            logic sd_before;
            hs        = tx_valid && tx_ready;
            scl_now   = SCL;
            sd_before = SDA_down;
            @(posedge FPGA_clk);
            @(negedge FPGA_clk);
            if (hs) begin
                hs_cnt++;
                void'(src_q.pop_front());
                set_source();
            end
            if (done)     done_cnt++;
            if (underrun) underrun_cnt++;
            if (SCL_down) stretch_cnt++;
            if (scl_now && rst_n && (SDA_down !== sd_before)) viol_cnt++;
        end
    endtask

    task automatic begin_transfer();
        low_t  = 3 + $urandom_range(0, 2);
        high_t = 2 + $urandom_range(0, 2);
        SCL    = 1'b1;
        SDA    = 1'b1;
        enable = 1'b1;
        tick(2);
        SCL = 1'b0;
    endtask

    task automatic end_transfer();
        enable = 1'b0;
        SCL    = 1'b1;
        SDA    = 1'b1;
        tick(2);
    endtask

    // One byte plus ACK slot as the master sees it; starts and ends with SCL low.
    task automatic master_byte(input logic ack_bit, output logic [7:0] seen,
                               output logic ack_release);
        seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(low_t);
            seen[7-i] = ~SDA_down;
            SCL = 1'b1;
            tick(high_t);
            SCL = 1'b0;
        end
        SDA = ack_bit;
        tick(low_t);
        ack_release = SDA_down;
        SCL = 1'b1;
        tick(high_t);
        SCL = 1'b0;
        tick(1);
        SDA = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        compared++;
        if ({SDA_down, SCL_down, done, nack, underrun, tx_ready, busy} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL reset.flags: got %b, expected 0000000",
                     {SDA_down, SCL_down, done, nack, underrun, tx_ready, busy});
        end
        compared++;
        if (byte_count !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset.byte_count: got %0d, expected 0", byte_count);
        end
        rst_n = 1'b1;
        tick(3);
        compared++;
        if ({SDA_down, SCL_down, busy, tx_ready} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset.idle: got %b, expected 0000",
                     {SDA_down, SCL_down, busy, tx_ready});
        end
    endtask

    task automatic test_single_nack();
        logic [7:0] seen;
        logic       rel;
        clear_monitors();
        src_q.push_back(8'hA5);
        set_source();
        begin_transfer();
        master_byte(1'b1, seen, rel);
        compared++;
        if (seen !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL single.data: got %h, expected a5", seen);
        end
        compared++;
        if (rel !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single.ack_release: got %b, expected 0", rel);
        end
        compared++;
        if ({nack, busy} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL single.nack_busy: got %b, expected 10", {nack, busy});
        end
        compared++;
        if (done_cnt !== 1 || hs_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL single.done_hs: got done=%0d hs=%0d, expected 1 1", done_cnt, hs_cnt);
        end
        compared++;
        if (byte_count !== BC_W'(1)) begin
            mismatched++;
            $display("[TB] FAIL single.byte_count: got %0d, expected 1", byte_count);
        end
        compared++;
        if (viol_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL single.sda_while_scl_high: got %0d changes, expected 0", viol_cnt);
        end
        end_transfer();
    endtask

    task automatic test_burst();
        logic [7:0] exp_bytes[3];
        logic       acks[3];
        logic [7:0] seen;
        logic       rel;
        exp_bytes = '{8'h00, 8'hFF, 8'h3C};
        acks      = '{1'b0, 1'b0, 1'b1};
        clear_monitors();
        for (int k = 0; k < 3; k++) src_q.push_back(exp_bytes[k]);
        set_source();
        begin_transfer();
        for (int k = 0; k < 3; k++) begin
            master_byte(acks[k], seen, rel);
            compared++;
            if (seen !== exp_bytes[k] || rel !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL burst.byte%0d: got %h rel=%b, expected %h rel=0",
                         k, seen, rel, exp_bytes[k]);
            end
            compared++;
            if (nack !== acks[k]) begin
                mismatched++;
                $display("[TB] FAIL burst.nack%0d: got %b, expected %b", k, nack, acks[k]);
            end
        end
        compared++;
        if (byte_count !== BC_W'(3) || hs_cnt !== 3 || done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL burst.totals: got count=%0d hs=%0d done=%0d, expected 3 3 1",
                     byte_count, hs_cnt, done_cnt);
        end
        end_transfer();
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int         len;
            int         exp_cnt;
            logic [7:0] exp_bytes[$];
            logic [7:0] seen;
            logic       rel;
            len = $urandom_range(1, 8);
            exp_bytes.delete();
            clear_monitors();
            for (int k = 0; k < len; k++) begin
                exp_bytes.push_back(8'($urandom));
                src_q.push_back(exp_bytes[k]);
            end
            set_source();
            begin_transfer();
            for (int k = 0; k < len; k++) begin
                master_byte(k == len - 1, seen, rel);
                exp_cnt = (k + 1 < NUM_BYTES) ? k + 1 : NUM_BYTES;
                compared++;
                if (seen !== exp_bytes[k] || rel !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL random.byte t=%0d k=%0d: got %h rel=%b, expected %h rel=0",
                             t, k, seen, rel, exp_bytes[k]);
                end
                compared++;
                if (byte_count !== BC_W'(exp_cnt)) begin
                    mismatched++;
                    $display("[TB] FAIL random.byte_count t=%0d k=%0d: got %0d, expected %0d",
                             t, k, byte_count, exp_cnt);
                end
            end
            compared++;
            if (done_cnt !== 1 || hs_cnt !== len || underrun_cnt !== 0 || stretch_cnt !== 0
                || viol_cnt !== 0 || nack !== 1'b1 || busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL random.end t=%0d: got done=%0d hs=%0d und=%0d str=%0d viol=%0d nack=%b busy=%b, expected 1 %0d 0 0 0 1 0",
                         t, done_cnt, hs_cnt, underrun_cnt, stretch_cnt, viol_cnt, nack, busy, len);
            end
            end_transfer();
        end
    endtask

`ifndef DATA_OUT_CLOCK_STRETCH_EN
    task automatic test_underrun();
        logic [7:0] first;
        logic [7:0] seen;
        logic       rel;
        first = 8'($urandom);
        clear_monitors();
        src_q.push_back(first);
        set_source();
        begin_transfer();
        master_byte(1'b0, seen, rel);
        compared++;
        if (seen !== first) begin
            mismatched++;
            $display("[TB] FAIL underrun.first: got %h, expected %h", seen, first);
        end
        master_byte(1'b1, seen, rel);
        compared++;
        if (seen !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL underrun.filler: got %h, expected ff", seen);
        end
        compared++;
        if (underrun_cnt !== 1 || hs_cnt !== 1 || stretch_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL underrun.pulses: got und=%0d hs=%0d str=%0d, expected 1 1 0",
                     underrun_cnt, hs_cnt, stretch_cnt);
        end
        compared++;
        if (byte_count !== BC_W'(2) || done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL underrun.totals: got count=%0d done=%0d, expected 2 1", byte_count, done_cnt);
        end
        end_transfer();
    endtask
`else
    task automatic test_stretch();
        logic [7:0] first;
        logic [7:0] seen;
        logic       rel;
        first = 8'($urandom);
        clear_monitors();
        src_q.push_back(first);
        set_source();
        begin_transfer();
        master_byte(1'b0, seen, rel);
        tick(20);
        compared++;
        if (stretch_cnt !== 20 || underrun_cnt !== 0 || tx_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stretch.hold: got str=%0d und=%0d ready=%b, expected 20 0 1",
                     stretch_cnt, underrun_cnt, tx_ready);
        end
        src_q.push_back(8'h80);
        set_source();
        tick(1);
        compared++;
        if (SCL_down !== 1'b0 || SDA_down !== 1'b0 || hs_cnt !== 2) begin
            mismatched++;
            $display("[TB] FAIL stretch.accept: got scl_down=%b sda_down=%b hs=%0d, expected 0 0 2",
                     SCL_down, SDA_down, hs_cnt);
        end
        master_byte(1'b1, seen, rel);
        compared++;
        if (seen !== 8'h80 || byte_count !== BC_W'(2) || done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL stretch.byte: got %h count=%0d done=%0d, expected 80 2 1",
                     seen, byte_count, done_cnt);
        end
        end_transfer();
    endtask
`endif

    task automatic test_stop_mid_byte();
        logic [7:0] b;
        logic [7:0] seen;
        b = 8'($urandom) & 8'hE7;
        seen = 8'h00;
        clear_monitors();
        src_q.push_back(b);
        set_source();
        begin_transfer();
        for (int i = 0; i < 4; i++) begin
            tick(low_t);
            seen[7-i] = ~SDA_down;
            SCL = 1'b1;
            tick(high_t);
            SCL = 1'b0;
        end
        SDA = 1'b0;
        tick(low_t);
        compared++;
        if (seen[7:4] !== b[7:4] || SDA_down !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stop.before: got bits %h sda_down=%b, expected %h 1",
                     seen[7:4], SDA_down, b[7:4]);
        end
        SCL = 1'b1;
        tick(2);
        SDA = 1'b1;
        tick(1);
        compared++;
        if (busy !== 1'b0 || SDA_down !== 1'b0 || done !== 1'b1 || done_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL stop.after: got busy=%b sda_down=%b done=%b done_cnt=%0d, expected 0 0 1 1",
                     busy, SDA_down, done, done_cnt);
        end
        end_transfer();
    endtask

    task automatic test_enable_drop();
        logic [7:0] b;
        b = 8'($urandom) & 8'hE7;
        clear_monitors();
        src_q.push_back(b);
        set_source();
        begin_transfer();
        for (int i = 0; i < 4; i++) begin
            tick(low_t);
            SCL = 1'b1;
            tick(high_t);
            SCL = 1'b0;
        end
        tick(low_t);
        SCL = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(1);
        compared++;
        if (busy !== 1'b0 || SDA_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL enable_drop.idle: got busy=%b sda_down=%b, expected 0 0", busy, SDA_down);
        end
        tick(3);
        compared++;
        if (done_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL enable_drop.done: got %0d pulses, expected 0", done_cnt);
        end
        end_transfer();
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] seen;
        logic       rel;
        clear_monitors();
        src_q.push_back(8'($urandom));
        src_q.push_back(8'($urandom) & 8'h7F);
        set_source();
        begin_transfer();
        master_byte(1'b0, seen, rel);
        tick(low_t);
        compared++;
        if (SDA_down !== 1'b1 || byte_count !== BC_W'(1)) begin
            mismatched++;
            $display("[TB] FAIL rst_mid.before: got sda_down=%b count=%0d, expected 1 1", SDA_down, byte_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({SDA_down, SCL_down, done, nack, underrun, tx_ready, busy} !== 7'b0
            || byte_count !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid.async: got flags=%b count=%0d, expected 0000000 0",
                     {SDA_down, SCL_down, done, nack, underrun, tx_ready, busy}, byte_count);
        end
        src_q.delete();
        set_source();
        enable = 1'b0;
        SCL    = 1'b1;
        SDA    = 1'b1;
        @(negedge FPGA_clk);
        rst_n = 1'b1;
        tick(2);
        compared++;
        if (busy !== 1'b0 || SDA_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid.after: got busy=%b sda_down=%b, expected 0 0", busy, SDA_down);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        SCL      = 1'b1;
        SDA      = 1'b1;
        enable   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        low_t    = 3;
        high_t   = 2;
        clear_monitors();
        @(negedge FPGA_clk);

        test_reset();
        test_single_nack();
        test_burst();
        test_random();
`ifndef DATA_OUT_CLOCK_STRETCH_EN
        test_underrun();
`else
        test_stretch();
`endif
        test_stop_mid_byte();
        test_enable_drop();
        test_reset_mid_transfer();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_out_controller.md
Name: data_out_controller

Overview:
- I2C slave transmit path for master-read transfers: the slave shifts bytes out on SDA, MSB first, and samples the master's ACK/NACK after each byte.
- Sits beside the Data In controller. The slave top asserts enable once a read address has been acknowledged.
- Bytes come from a valid/ready byte source (register file or FIFO).
- The SDA pad is open-drain: the block only requests pull-low through SDA_down.

Parameters:
- NUM_BYTES, 6, maximum bytes counted per transaction; sets the byte_count width to $clog2(NUM_BYTES)+1.

Ports:
- FPGA_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- SCL  in  1  bus clock, already synchronised to FPGA_clk.
- SDA  in  1  bus data, already synchronised to FPGA_clk.
- enable  in  1  read transfer armed by the slave top; level-sensitive.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  byte accepted this cycle when tx_valid&tx_ready.
- SDA_down  out  1  1 = pull SDA low; 0 = release.
- SCL_down  out  1  1 = hold SCL low (clock stretch); tied 0 when stretching is not compiled in.
- done  out  1  one-cycle pulse at transfer end.
- nack  out  1  master NACKed the last byte; held until the next transfer start.
- underrun  out  1  one-cycle pulse when 0xFF is sent because no byte was available.
- byte_count  out  $clog2(NUM_BYTES)+1  bytes fully shifted this transfer; saturates at NUM_BYTES.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; SCL_prev=1, SDA_prev=1.
  - Outputs: SDA_down=0, SCL_down=0, done=0, nack=0, underrun=0, tx_ready=0, byte_count=0, busy=0.
  - Shift register 0xFF, bit_count=0.
- Edge detect:
  - SCL_prev/SDA_prev are internal registers of SCL/SDA.
  - fall = ~SCL & SCL_prev; rise = SCL & ~SCL_prev.
  - stop = SCL & SCL_prev & SDA & ~SDA_prev.
  - start = SCL & SCL_prev & ~SDA & SDA_prev.
- IDLE:
  - Outputs released.
  - enable & fall → LOAD; clear nack, byte_count, bit_count.
- LOAD:
  - tx_ready=1 combinationally.
  - If tx_valid: shift<=tx_data, SDA_down<=~tx_data[7], bit_count<=0 → DRIVE.
  - If no tx_valid: see Optional Feature.
  - SDA_down settles 2 FPGA_clk cycles after SCL=0 is first sampled.
- DRIVE:
  - On fall with bit_count<7: shift left, SDA_down<=~shift[6], bit_count++.
  - On fall with bit_count==7: SDA_down<=0, byte_count++ (saturate at NUM_BYTES) → ACK_SLOT.
  - SDA_down never changes while SCL is high.
- ACK_SLOT:
  - SDA released.
  - On rise: nack<=SDA.
  - On fall with nack=0 → LOAD.
  - On fall with nack=1 → IDLE with done pulse.
- Abort conditions:
  - From any non-IDLE state, stop or start → IDLE: SDA_down<=0, SCL_down<=0, done pulse (stop only).
  - enable=0 in any non-IDLE state → IDLE immediately, SDA released, no done.
  - Abort priority order: enable low > stop/start > edge handling.
- byte_count saturates; it never wraps.
- bit_count is 3 bits and is reset on every LOAD.
- All outputs are registered except tx_ready and busy.

Optional Feature:
- Macro: DATA_OUT_CLOCK_STRETCH_EN.
- Defined: LOAD with tx_valid=0 sets SCL_down=1 and stays in LOAD until tx_valid. SCL_down<=0 in the same cycle the byte is accepted. No underrun is reported.
- Undefined: LOAD with tx_valid=0 loads 0xFF, pulses underrun, leaves SDA_down=0, goes to DRIVE. SCL_down is constant 0.

Test Plan:
- Single byte, master NACK: enable, tx_data=0xA5 valid.
  - Expected SDA bits 1,0,1,0,0,1,0,1 across 8 SCL pulses (SDA_down the inverse of each bit).
  - Then SDA=1 at the 9th rise → nack=1, done pulse, byte_count=1, IDLE.
- Multi-byte burst: bytes 0x00, 0xFF, 0x3C with ACK, ACK, NACK.
  - Expected: three tx_ready handshakes, the correct bit streams, byte_count=3, one done.
- Underrun (macro off): tx_valid=0 at second LOAD.
  - Expected: byte 0xFF sent, SDA_down=0 throughout, underrun pulses once.
- Clock stretch (macro on): tx_valid held low 20 cycles in LOAD.
  - Expected: SCL_down=1 for those cycles, then 0 on acceptance; first bit of 0x80 drives SDA_down=0.
- STOP mid-byte: SDA rises while SCL high at bit 4.
  - Expected: IDLE next cycle, SDA_down=0, done pulse.
  - Separately, enable dropped mid-byte → IDLE, no done.
- Reset mid-transfer: rst_n low during DRIVE with SDA_down=1.
  - Expected: SDA_down=0 asynchronously, all outputs at reset values.
